// File: rtl/div_ctrl_pkg.sv
// div_ctrl_pkg: shared widths, op bit indices, state encodings and result word select for div_ctrl
// Ports: none (package)
package div_ctrl_pkg;
    localparam int DIV_DATA_WD = 32;
    localparam int DIV_OP_WD   = 4;
    localparam int DIV_RES_WD  = 2 * DIV_DATA_WD;
    localparam int DIV_OP_DIV_WU = 1;
    localparam int DIV_OP_MOD_W  = 2;
    localparam int DIV_OP_MOD_WU = 3;
    localparam logic [2:0] DIV_ST_IDLE  = 3'd0;
    localparam logic [2:0] DIV_ST_SEND  = 3'd1;
    localparam logic [2:0] DIV_ST_WAIT  = 3'd2;
    localparam logic [2:0] DIV_ST_DONE  = 3'd3;
    localparam logic [2:0] DIV_ST_DRAIN = 3'd4;
    // core result is {quotient, remainder}
    function automatic logic [DIV_DATA_WD-1:0] div_pick(input logic is_mod, input logic [DIV_RES_WD-1:0] d);
        return is_mod ? d[DIV_DATA_WD-1:0] : d[DIV_RES_WD-1:DIV_DATA_WD];
    endfunction
endpackage

// File: rtl/div_ctrl_if.sv
// div_ctrl_if: EX-side request/flush, operand AXI-stream channels and result channel of the divide sequencer
// Ports: slave = div_ctrl view, master = EX stage / divider core view
interface div_ctrl_if #(
    parameter int DATA_WD = div_ctrl_pkg::DIV_DATA_WD,
    parameter int OP_WD   = div_ctrl_pkg::DIV_OP_WD
);
    logic                 es_valid;
    logic [OP_WD-1:0]     div_op;
    logic [DATA_WD-1:0]   div_src1;
    logic [DATA_WD-1:0]   div_src2;
    logic                 es_go;
    logic                 div_cancel;
    logic                 s_dvd_tvalid;
    logic                 s_dvs_tvalid;
    logic                 s_dvd_tready;
    logic                 s_dvs_tready;
    logic                 core_sel_u;
    logic [DATA_WD-1:0]   s_dvd_tdata;
    logic [DATA_WD-1:0]   s_dvs_tdata;
    logic                 m_dout_tvalid;
    logic [2*DATA_WD-1:0] m_dout_tdata;
    logic                 div_ready_go;
    logic [DATA_WD-1:0]   div_result;
    modport slave (
        input  es_valid, div_op, div_src1, div_src2, es_go, div_cancel,
        input  s_dvd_tready, s_dvs_tready, m_dout_tvalid, m_dout_tdata,
        output s_dvd_tvalid, s_dvs_tvalid, core_sel_u, s_dvd_tdata, s_dvs_tdata,
        output div_ready_go, div_result
    );
    modport master (
        output es_valid, div_op, div_src1, div_src2, es_go, div_cancel,
        output s_dvd_tready, s_dvs_tready, m_dout_tvalid, m_dout_tdata,
        input  s_dvd_tvalid, s_dvs_tvalid, core_sel_u, s_dvd_tdata, s_dvs_tdata,
        input  div_ready_go, div_result
    );
endinterface

// File: rtl/div_ctrl_axis_chan.sv
// div_ctrl_axis_chan: one AXI-stream operand channel, holds tvalid until handshake and remembers it happened
// Ports: clk, reset (async, active-high); i_start raises tvalid and clears the seen flag;
//        i_drop withdraws tvalid; i_tready from the core; o_tvalid; o_done = handshake seen or happening now
module div_ctrl_axis_chan (
    input  logic clk,
    input  logic reset,
    input  logic i_start,
    input  logic i_drop,
    input  logic i_tready,
    output logic o_tvalid,
    output logic o_done
);
    logic r_tvalid;
    logic r_seen;
    logic w_hs;

    assign w_hs     = r_tvalid & i_tready;
    assign o_tvalid = r_tvalid;
    assign o_done   = r_seen | w_hs;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tvalid <= 1'b0;
            r_seen   <= 1'b0;
        end else begin
            r_tvalid <= i_start | (r_tvalid & ~i_tready & ~i_drop);
            r_seen   <= ~i_start & (r_seen | w_hs);
        end
    end
endmodule

// File: rtl/div_ctrl.sv
// div_ctrl: sequences one EX divide through the external divider cores and stalls EX until the word is ready
// Ports: clk, reset (async, active-high); bus (div_ctrl_if.slave) carries the EX request and flush,
//        both operand channels, the core result channel, core_sel_u, div_ready_go and div_result
module div_ctrl
    import div_ctrl_pkg::*;
(
    input logic       clk,
    input logic       reset,
    div_ctrl_if.slave bus
);
    logic [2:0]             r_state;
    logic [2:0]             w_next;
    logic [DIV_DATA_WD-1:0] r_dvd;
    logic [DIV_DATA_WD-1:0] r_dvs;
    logic [DIV_DATA_WD-1:0] r_res;
    logic                   r_mod;
    logic                   r_sel_u;
    logic                   r_cxl;
    logic                   w_req;
    logic                   w_start;
    logic                   w_drop;
    logic                   w_take;
    logic                   w_dvd_done;
    logic                   w_dvs_done;

    assign w_req   = bus.es_valid & (|bus.div_op) & ~bus.div_cancel;
    assign w_start = (r_state == DIV_ST_IDLE) & w_req;
    // a flush before either operand reached the core withdraws the request with nothing to drain
    assign w_drop  = (r_state == DIV_ST_SEND) & bus.div_cancel & ~(w_dvd_done | w_dvs_done);
    assign w_take  = (r_state == DIV_ST_WAIT) & bus.m_dout_tvalid & ~bus.div_cancel;

    div_ctrl_axis_chan u_dvd (
        .clk      (clk),
        .reset    (reset),
        .i_start  (w_start),
        .i_drop   (w_drop),
        .i_tready (bus.s_dvd_tready),
        .o_tvalid (bus.s_dvd_tvalid),
        .o_done   (w_dvd_done)
    );

    div_ctrl_axis_chan u_dvs (
        .clk      (clk),
        .reset    (reset),
        .i_start  (w_start),
        .i_drop   (w_drop),
        .i_tready (bus.s_dvs_tready),
        .o_tvalid (bus.s_dvs_tvalid),
        .o_done   (w_dvs_done)
    );

    // a result landing in the same cycle as a flush in WAIT is the one to drain, so go straight to IDLE
    always_comb begin
        w_next = r_state;
        case (r_state)
            DIV_ST_IDLE:  w_next = w_req ? DIV_ST_SEND : DIV_ST_IDLE;
            DIV_ST_SEND:  w_next = (w_dvd_done & w_dvs_done) ? ((bus.div_cancel | r_cxl) ? DIV_ST_DRAIN : DIV_ST_WAIT)
                                                             : (w_drop ? DIV_ST_IDLE : DIV_ST_SEND);
            DIV_ST_WAIT:  w_next = bus.m_dout_tvalid ? (bus.div_cancel ? DIV_ST_IDLE : DIV_ST_DONE)
                                                     : (bus.div_cancel ? DIV_ST_DRAIN : DIV_ST_WAIT);
            DIV_ST_DONE:  w_next = (bus.es_go | bus.div_cancel) ? DIV_ST_IDLE : DIV_ST_DONE;
            DIV_ST_DRAIN: w_next = bus.m_dout_tvalid ? DIV_ST_IDLE : DIV_ST_DRAIN;
            default:      w_next = DIV_ST_IDLE;
        endcase
    end

    // r_cxl remembers a flush seen while one channel is still waiting for its handshake
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= DIV_ST_IDLE;
            r_dvd   <= '0;
            r_dvs   <= '0;
            r_res   <= '0;
            r_mod   <= 1'b0;
            r_sel_u <= 1'b0;
            r_cxl   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_start) begin
                r_dvd   <= bus.div_src1;
                r_dvs   <= bus.div_src2;
                r_mod   <= bus.div_op[DIV_OP_MOD_W] | bus.div_op[DIV_OP_MOD_WU];
                r_sel_u <= bus.div_op[DIV_OP_DIV_WU] | bus.div_op[DIV_OP_MOD_WU];
            end
            r_cxl <= ~w_start & (r_cxl | ((r_state == DIV_ST_SEND) & bus.div_cancel));
            if (w_take)
                r_res <= div_pick(r_mod, bus.m_dout_tdata);
        end
    end

    assign bus.s_dvd_tdata  = r_dvd;
    assign bus.s_dvs_tdata  = r_dvs;
    assign bus.core_sel_u   = r_sel_u;
    assign bus.div_result   = r_res;
    assign bus.div_ready_go = (r_state == DIV_ST_DONE) & ~bus.div_cancel;
endmodule
